// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage for fifo_async.
// Turns the FIFO rd_en/rdata/empty port into a valid/ready stream. A 2-entry
// buffer absorbs the FIFO's one-cycle read latency. The block also counts
// delivered words and keeps a sticky FIFO read-error flag.
module fifo_rd_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 rd_clk_i,
    input  logic                 rst_n_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_rd_error_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] word_cnt_o,
    output logic                 rd_err_o
);

    // Buffer occupancy.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_inflight;
    logic                 r_drop;
    logic [WIDTH-1:0]     r_head;
    logic [WIDTH-1:0]     r_tail;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic                 r_rd_err;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_room;
    logic                 w_rd_en;

    // Occupancy register.
    always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next occupancy, pop/push decode and the read strobe.
    // The strobe is gated by rst_n_i so it reads 0 while reset is held.
    // It is also gated by flush_i, because a flushed cycle must not start a read.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_push       = 1'b0;
        w_room       = 1'b0;
        w_rd_en      = 1'b0;

        w_pop  = (r_state != S_EMPTY) & m_ready_i;
        w_push = r_inflight & ~r_drop & ~flush_i;

        // Room exists when count + inflight - pop < 2.
        case (r_state)
            S_EMPTY: begin
                w_room = 1'b1;
                if (w_push) begin
                    w_state_next = S_ONE;
                end
            end
            S_ONE: begin
                w_room = ~r_inflight | w_pop;
                if (w_push && !w_pop) begin
                    w_state_next = S_TWO;
                end else if (!w_push && w_pop) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                w_room = w_pop & ~r_inflight;
                if (w_pop && !w_push) begin
                    w_state_next = S_ONE;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase

        if (flush_i) begin
            w_state_next = S_EMPTY;
        end

        w_rd_en = rst_n_i & ~fifo_empty_i & ~flush_i & w_room;
    end

    // Read-in-flight tracking; a read pending at a flush edge is marked for dropping.
    always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_drop     <= flush_i & r_inflight;
        end
    end

    // Two-entry FIFO-ordered buffer: head is presented, tail is the second word.
    always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (!flush_i) begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_state == S_EMPTY) begin
                        r_head <= fifo_rdata_i;
                    end else begin
                        r_tail <= fifo_rdata_i;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                end
                2'b11: begin
                    if (r_state == S_ONE) begin
                        r_head <= fifo_rdata_i;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= fifo_rdata_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Count handshakes that are not cancelled by a flush in the same cycle.
    always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_word_cnt <= '0;
        end else if (w_pop && !flush_i) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

    // Sticky FIFO read-error flag, cleared only by reset.
    always_ff @(posedge rd_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_err <= 1'b0;
        end else if (fifo_rd_error_i) begin
            r_rd_err <= 1'b1;
        end
    end

    assign fifo_rd_en_o = w_rd_en;
    assign m_valid_o    = (r_state != S_EMPTY);
    assign m_data_o     = r_head;
    assign word_cnt_o   = r_word_cnt;
    assign rd_err_o     = r_rd_err;

endmodule
